// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: latches one instruction and walks DECODE/EXEC/MEM/WB.
// Optional build macro MIPS_CTRL_ILLEGAL_TRAP_EN: unsupported instructions lock into TRAP until reset.
module mips_multicycle_control #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4,
  parameter int LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic [REG_ADDR_W-1:0] read_reg_1,
  output logic [REG_ADDR_W-1:0] read_reg_2,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic                  signal_reg_write,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  alu_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  pc_write,
  output logic                  instr_done,
  output logic                  illegal_instr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b1001;

  state_t      state_r;
  logic [31:0] ir_r;

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic        legal_s;
  logic        unused_ok;

  assign op_s    = ir_r[31:26];
  assign funct_s = ir_r[5:0];
  assign legal_s = is_legal(ir_r);
  // Shamt bits and the reserved link register index are not consumed by control.
  assign unused_ok = &{1'b0, ir_r[10:6], (LINK_REG != 0)};

  function automatic logic is_legal(input logic [31:0] w);
    logic ok;
    case (w[31:26])
      OP_RTYPE: begin
        case (w[5:0])
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: ok = 1'b1;
          default:                                        ok = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW:                     ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [ALU_OP_W-1:0] alu_op_of(input logic [31:0] w);
    logic [ALU_OP_W-1:0] r;
    case (w[31:26])
      OP_RTYPE: begin
        case (w[5:0])
          6'h20:   r = ALU_ADD;
          6'h22:   r = ALU_SUB;
          6'h24:   r = ALU_AND;
          6'h25:   r = ALU_OR;
          6'h2A:   r = ALU_SLT;
          6'h00:   r = ALU_SLL;
          6'h02:   r = ALU_SRL;
          default: r = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: r = ALU_SUB;
      OP_SLTI:        r = ALU_SLT;
      OP_ANDI:        r = ALU_AND;
      OP_ORI:         r = ALU_OR;
      default:        r = ALU_ADD;
    endcase
    return r;
  endfunction

  // State register and instruction latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      ir_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (instr_valid) begin
            ir_r    <= instr;
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal_s) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            state_r <= S_TRAP;
`else
            state_r <= S_IDLE;
`endif
          end else if (op_s == OP_J) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_s == OP_BEQ || op_s == OP_BNE) begin
            state_r <= S_IDLE;
          end else if (op_s == OP_LW || op_s == OP_SW) begin
            state_r <= S_MEM;
          end else begin
            state_r <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state_r <= (op_s == OP_LW) ? S_WB : S_IDLE;
          end
        end
        S_WB:    state_r <= S_IDLE;
        S_TRAP:  state_r <= S_TRAP;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Moore output decode of state and latched instruction; pc_write and sw retire see inputs.
  always_comb begin
    instr_ready      = 1'b0;
    read_reg_1       = '0;
    read_reg_2       = '0;
    write_reg        = '0;
    signal_reg_write = 1'b0;
    alu_op           = '0;
    alu_src          = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_to_reg       = 1'b0;
    pc_write         = 1'b0;
    instr_done       = 1'b0;
    illegal_instr    = 1'b0;
    if (state_r == S_DECODE || state_r == S_EXEC || state_r == S_MEM || state_r == S_WB) begin
      read_reg_1 = ir_r[25:21];
      read_reg_2 = ir_r[20:16];
    end else begin
      read_reg_1 = '0;
      read_reg_2 = '0;
    end
    case (state_r)
      S_IDLE: instr_ready = 1'b1;
      S_DECODE: begin
        if (!legal_s) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          instr_done = 1'b0;
`else
          instr_done = 1'b1;
`endif
        end else if (op_s == OP_J) begin
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end else begin
          instr_done = 1'b0;
        end
      end
      S_EXEC: begin
        alu_op  = alu_op_of(ir_r);
        alu_src = (op_s != OP_RTYPE) && (op_s != OP_BEQ) && (op_s != OP_BNE);
        if (op_s == OP_BEQ || op_s == OP_BNE) begin
          pc_write   = alu_zero ^ (op_s == OP_BNE);
          instr_done = 1'b1;
        end else begin
          pc_write   = 1'b0;
        end
      end
      S_MEM: begin
        mem_read  = (op_s == OP_LW);
        mem_write = (op_s == OP_SW);
        if (op_s == OP_SW && mem_ready) begin
          instr_done = 1'b1;
        end else begin
          instr_done = 1'b0;
        end
      end
      S_WB: begin
        write_reg        = (op_s == OP_RTYPE) ? ir_r[15:11] : ir_r[20:16];
        mem_to_reg       = (op_s == OP_LW);
        signal_reg_write = (write_reg != '0);
        instr_done       = 1'b1;
      end
      S_TRAP:  illegal_instr = 1'b1;
      default: instr_ready   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: hand-computed vectors checked with immediate assertions.
module tb_mips_multicycle_control;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_zero;
  logic        mem_ready;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [4:0]  write_reg;
  logic        signal_reg_write;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        pc_write;
  logic        instr_done;
  logic        illegal_instr;

  int vectors;
  int miscompares;

  mips_multicycle_control dut (
    .clk              (clk),
    .reset            (reset),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .alu_zero         (alu_zero),
    .mem_ready        (mem_ready),
    .read_reg_1       (read_reg_1),
    .read_reg_2       (read_reg_2),
    .write_reg        (write_reg),
    .signal_reg_write (signal_reg_write),
    .alu_op           (alu_op),
    .alu_src          (alu_src),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_to_reg       (mem_to_reg),
    .pc_write         (pc_write),
    .instr_done       (instr_done),
    .illegal_instr    (illegal_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accept edge; returns in DECODE (cycle 1).
  task automatic issue(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr       = 32'h0000_0000;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    instr       = 32'h0000_0000;
    instr_valid = 1'b0;
    alu_zero    = 1'b0;
    mem_ready   = 1'b0;
    step();
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_outs", {16'd0, read_reg_1, read_reg_2, signal_reg_write, mem_read, mem_write, pc_write, instr_done, illegal_instr}, 32'd0);
    reset = 1'b0;
    step();

    // add $2,$14,$10
    issue(32'h01CA_1020);
    chk("add_dec_rr1", {27'd0, read_reg_1}, 32'd14);
    chk("add_dec_rr2", {27'd0, read_reg_2}, 32'd10);
    chk("add_dec_rdy", {31'd0, instr_ready}, 32'd0);
    step();
    chk("add_ex_aluop", {28'd0, alu_op}, 32'h2);
    chk("add_ex_src", {31'd0, alu_src}, 32'd0);
    chk("add_ex_done", {31'd0, instr_done}, 32'd0);
    step();
    chk("add_wb_wr", {27'd0, write_reg}, 32'd2);
    chk("add_wb_we", {31'd0, signal_reg_write}, 32'd1);
    chk("add_wb_done", {31'd0, instr_done}, 32'd1);
    step();
    chk("add_idle", {30'd0, instr_ready, instr_done}, 32'b10);

    // lw $8,4($15) with 3 stall cycles and a stray instr_valid while busy
    issue(32'h8DE8_0004);
    chk("lw_dec_rr1", {27'd0, read_reg_1}, 32'd15);
    step();
    chk("lw_ex_aluop", {28'd0, alu_op}, 32'h2);
    chk("lw_ex_src", {31'd0, alu_src}, 32'd1);
    instr       = 32'h0800_0010;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lw_mem_stall_rd", {31'd0, mem_read}, 32'd1);
      chk("lw_mem_stall_done", {31'd0, instr_done}, 32'd0);
    end
    instr_valid = 1'b0;
    instr       = 32'h0000_0000;
    step();
    mem_ready = 1'b1;
    #1;
    chk("lw_mem_last_rd", {31'd0, mem_read}, 32'd1);
    chk("lw_mem_last_done", {31'd0, instr_done}, 32'd0);
    step();
    mem_ready = 1'b0;
    chk("lw_wb_wr", {27'd0, write_reg}, 32'd8);
    chk("lw_wb_m2r", {31'd0, mem_to_reg}, 32'd1);
    chk("lw_wb_we_done", {30'd0, signal_reg_write, instr_done}, 32'b11);
    chk("lw_wb_rd_off", {31'd0, mem_read}, 32'd0);
    step();
    chk("lw_idle", {31'd0, instr_ready}, 32'd1);

    // beq taken, then not taken
    alu_zero = 1'b1;
    issue(32'h1022_0003);
    chk("beq_dec_pc", {31'd0, pc_write}, 32'd0);
    step();
    chk("beq_t_aluop", {28'd0, alu_op}, 32'h6);
    chk("beq_t_pc_done", {30'd0, pc_write, instr_done}, 32'b11);
    step();
    chk("beq_t_idle", {31'd0, instr_ready}, 32'd1);
    alu_zero = 1'b0;
    issue(32'h1022_0003);
    step();
    chk("beq_nt_pc_done", {30'd0, pc_write, instr_done}, 32'b01);
    step();

    // bne with alu_zero=0 is taken
    issue(32'h1422_0003);
    step();
    chk("bne_pc_done", {30'd0, pc_write, instr_done}, 32'b11);
    step();

    // add $0: no register write
    issue(32'h01CA_0020);
    step();
    step();
    chk("add0_wb", {25'd0, write_reg, signal_reg_write, instr_done}, 32'b01);
    step();

    // j: retire in DECODE
    issue(32'h0800_0010);
    chk("j_dec", {30'd0, pc_write, instr_done}, 32'b11);
    step();
    chk("j_idle", {29'd0, instr_ready, pc_write, instr_done}, 32'b100);

    // ori $8,$15,4
    issue(32'h35E8_0004);
    step();
    chk("ori_ex", {27'd0, alu_op, alu_src}, {27'd0, 4'b0001, 1'b1});
    step();
    chk("ori_wb", {26'd0, write_reg, signal_reg_write}, {26'd0, 5'd8, 1'b1});
    step();

    // srl $2,$10,2
    issue(32'h000A_1082);
    step();
    chk("srl_ex", {27'd0, alu_op, alu_src}, {27'd0, 4'b1001, 1'b0});
    step();
    step();

    // sw with mem_ready already high: done at cycle 3
    mem_ready = 1'b1;
    issue(32'hADE8_0004);
    step();
    step();
    chk("sw_mem_fast", {29'd0, mem_write, mem_read, instr_done}, 32'b101);
    step();
    mem_ready = 1'b0;
    chk("sw_fast_idle", {30'd0, instr_ready, mem_write}, 32'b10);

    // unsupported opcode
    issue(32'hFC00_0000);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    chk("ill_dec_done", {31'd0, instr_done}, 32'd0);
    step();
    step();
    chk("ill_trap", {29'd0, illegal_instr, instr_ready, instr_done}, 32'b100);
    reset = 1'b1;
    #1;
    chk("ill_reset", {30'd0, illegal_instr, instr_ready}, 32'b01);
    reset = 1'b0;
    step();
`else
    chk("ill_nop", {28'd0, instr_done, illegal_instr, pc_write, signal_reg_write}, 32'b1000);
    step();
    chk("ill_idle", {30'd0, instr_ready, illegal_instr}, 32'b10);
    // unsupported R-type funct (addu)
    issue(32'h01CA_1021);
    chk("ill_funct_nop", {30'd0, instr_done, illegal_instr}, 32'b10);
    step();
`endif

    // reset in MEM of sw aborts the store
    issue(32'hADE8_0004);
    step();
    step();
    chk("sw_mem_wr", {31'd0, mem_write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("sw_rst_abort", {29'd0, mem_write, instr_ready, instr_done}, 32'b010);
    #1;
    reset = 1'b0;
    step();
    chk("sw_rst_after", {29'd0, mem_write, instr_ready, instr_done}, 32'b010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
